// File: rtl/lumi_pkg.sv
`timescale 1ns/1ps
// lumi_pkg: constants and helpers shared by the lumi serializer/deserializer pair.
// Latency: n/a (package only).
// Backpressure: n/a.
package lumi_pkg;

  // Word width on the lumi link and the clk_ser:clk_par ratio.
  localparam int LUMI_W     = 16;
  localparam int LUMI_RATIO = 8;

  // Training/idle word sent by the transmitter during alignment.
  localparam logic [LUMI_W-1:0] LUMI_SYNC_WORD = 16'hBC50;

  // Alignment FSM states; the encoding is visible on state_dbg.
  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    CHECK  = 2'b01,
    LOCKED = 2'b10
  } lumi_state_e;

  // 16-bit window starting slip_v bits into {prev_w, raw_w}, first line bit at bit 15.
  function automatic logic [LUMI_W-1:0] lumi_window(
    input logic [LUMI_W-1:0] prev_w,
    input logic [LUMI_W-1:0] raw_w,
    input logic [3:0]        slip_v
  );
    logic [2*LUMI_W-1:0] cat;
    cat = {prev_w, raw_w};
    return cat[5'd31 - {1'b0, slip_v} -: LUMI_W];
  endfunction

endpackage

// File: rtl/lumi_deserializer_if.sv
`timescale 1ns/1ps
// lumi_deserializer_if: aligned parallel word bus out of the lumi deserializer.
// Latency: n/a (wires only).
// Backpressure: none; the sink must accept a word every clk_par cycle while parOutValid is high.
// Signals: parOutWord[15:0] aligned word (bit15 = first bit on line), parOutValid word strobe.
// Modports: master (deserializer drives), slave (downstream lumi processing reads).
interface lumi_deserializer_if;
  logic [lumi_pkg::LUMI_W-1:0] parOutWord;
  logic                        parOutValid;

  modport master (output parOutWord, output parOutValid);
  modport slave  (input  parOutWord, input  parOutValid);
endinterface

// File: rtl/lumi_deser_capture.sv
`timescale 1ns/1ps
// lumi_deser_capture: clk_ser side of the lumi deserializer (DDR sampling, 16-bit shift, raw_hold).
// Latency: a word is complete in o_raw_hold once per 8 clk_ser cycles; phase set by the free counter.
// Backpressure: none; the line is sampled every edge of clk_ser.
// Ports: i_clk_ser serial clock, i_reset_n clk_par-domain sync reset (resynchronised here),
//        i_ser_data DDR line, o_raw_hold[15:0] held word, stable for 8 clk_ser cycles.
module lumi_deser_capture
  import lumi_pkg::*;
(
  input  logic              i_clk_ser,
  input  logic              i_reset_n,
  input  logic              i_ser_data,
  output logic [LUMI_W-1:0] o_raw_hold
);

  localparam int CNT_W = $clog2(LUMI_RATIO);

  logic [1:0]        r_rst_sync;
  logic              w_rst_ser;
  logic              r_p_smp;
  logic              r_n_smp;
  logic [LUMI_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [LUMI_W-1:0] r_raw_hold;

  // Two-flop synchronizer bringing reset_n into clk_ser.
  always_ff @(posedge i_clk_ser) begin
    r_rst_sync <= {r_rst_sync[0], i_reset_n};
  end

  assign w_rst_ser = ~r_rst_sync[1];

  // N bit: sampled on the negedge that follows the P sample of the same clk_ser cycle.
  always_ff @(negedge i_clk_ser) begin
    r_n_smp <= i_ser_data;
  end

  // At each posedge the previous cycle's {P,N} pair is complete and shifts in, P first.
  always_ff @(posedge i_clk_ser) begin
    if (w_rst_ser) begin
      r_p_smp    <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_raw_hold <= '0;
    end else begin
      r_p_smp <= i_ser_data;
      r_shift <= {r_shift[LUMI_W-3:0], r_p_smp, r_n_smp};
      r_cnt   <= r_cnt + 1'b1;
      // raw_hold only changes here, so clk_par sees a value stable for a whole clk_par period.
      if (r_cnt == CNT_W'(LUMI_RATIO - 1)) begin
        r_raw_hold <= r_shift;
      end
    end
  end

  assign o_raw_hold = r_raw_hold;

endmodule

// File: rtl/lumi_deserializer.sv
`timescale 1ns/1ps
// lumi_deserializer: DDR lumi receiver; finds the word boundary by bit-slipping on SYNC_WORD.
// Latency: fixed after lock, 3 clk_par cycles plus the fixed clk_ser-side phase; same for every relock at a slip.
// Backpressure: none; parOutValid is high every clk_par cycle while locked.
// Ports: clk_par/reset_n (sync, active-low), clk_ser (8x clk_par), serInData DDR line,
//        realign re-search pulse, par_if (parOutWord/parOutValid), aligned, slip[3:0], state_dbg[1:0].
// Optional: define LUMI_DESER_STATS_EN for saturating lock_cnt[15:0] and slip_wraps[15:0] outputs.
module lumi_deserializer
  import lumi_pkg::*;
#(
  parameter logic [LUMI_W-1:0] SYNC_WORD  = LUMI_SYNC_WORD,
  parameter int                LOCK_COUNT = 8,
  parameter int                SLIP_WAIT  = 2
) (
  input  logic                 clk_par,
  input  logic                 reset_n,
  input  logic                 clk_ser,
  input  logic                 serInData,
  input  logic                 realign,
  lumi_deserializer_if.master  par_if,
  output logic                 aligned,
  output logic [3:0]           slip,
  output logic [1:0]           state_dbg
`ifdef LUMI_DESER_STATS_EN
  ,
  output logic [15:0]          lock_cnt,
  output logic [15:0]          slip_wraps
`endif
);

  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  logic [LUMI_W-1:0] w_raw_hold;
  logic [LUMI_W-1:0] r_raw;
  logic [LUMI_W-1:0] r_prev;
  logic [LUMI_W-1:0] r_word;
  logic [LUMI_W-1:0] w_window;
  logic              w_match;

  lumi_state_e       r_state;
  lumi_state_e       w_state_nxt;
  logic [3:0]        r_slip;
  logic [3:0]        w_slip_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [7:0]        r_match;
  logic [7:0]        w_match_nxt;

  lumi_deser_capture u_capture (
    .i_clk_ser  (clk_ser),
    .i_reset_n  (reset_n),
    .i_ser_data (serInData),
    .o_raw_hold (w_raw_hold)
  );

  // raw_hold is a multicycle path from clk_ser; it is stable whenever clk_par samples it.
  always_ff @(posedge clk_par) begin
    if (!reset_n) begin
      r_raw  <= '0;
      r_prev <= '0;
      r_word <= '0;
    end else begin
      r_raw  <= w_raw_hold;
      r_prev <= r_raw;
      r_word <= w_window;
    end
  end

  assign w_window = lumi_window(r_prev, r_raw, r_slip);
  assign w_match  = (w_window == SYNC_WORD);

  // FSM state register (with its slip / wait / match counters).
  always_ff @(posedge clk_par) begin
    if (!reset_n) begin
      r_state <= SEARCH;
      r_slip  <= '0;
      r_wait  <= '0;
      r_match <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slip  <= w_slip_nxt;
      r_wait  <= w_wait_nxt;
      r_match <= w_match_nxt;
    end
  end

  // FSM next-state logic. realign overrides everything, including a lock on this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_slip_nxt  = r_slip;
    w_wait_nxt  = r_wait;
    w_match_nxt = r_match;
    if (realign) begin
      w_state_nxt = SEARCH;
      w_wait_nxt  = WAIT_W'(SLIP_WAIT);
      w_match_nxt = '0;
    end else begin
      case (r_state)
        SEARCH: begin
          if (r_wait != '0) begin
            // Window still reflects the previous slip setting; ignore it.
            w_wait_nxt = r_wait - 1'b1;
          end else if (w_match) begin
            w_state_nxt = CHECK;
            w_match_nxt = 8'd1;
          end else begin
            w_slip_nxt = r_slip + 4'd1;
            w_wait_nxt = WAIT_W'(SLIP_WAIT);
          end
        end
        CHECK: begin
          if (r_match >= 8'(LOCK_COUNT)) begin
            // Only reachable with LOCK_COUNT == 1: the first match already locks.
            w_state_nxt = LOCKED;
          end else if (w_match) begin
            w_match_nxt = r_match + 8'd1;
            if (r_match + 8'd1 == 8'(LOCK_COUNT)) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_state_nxt = SEARCH;
            w_slip_nxt  = r_slip + 4'd1;
            w_wait_nxt  = WAIT_W'(SLIP_WAIT);
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          w_state_nxt = LOCKED;
        end
        default: begin
          w_state_nxt = SEARCH;
          w_match_nxt = '0;
        end
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    aligned            = (r_state == LOCKED);
    par_if.parOutValid = (r_state == LOCKED);
    par_if.parOutWord  = r_word;
    slip               = r_slip;
    state_dbg          = r_state;
  end

`ifdef LUMI_DESER_STATS_EN
  logic [15:0] r_lock_cnt;
  logic [15:0] r_slip_wraps;

  always_ff @(posedge clk_par) begin
    if (!reset_n) begin
      r_lock_cnt   <= '0;
      r_slip_wraps <= '0;
    end else begin
      if (w_state_nxt == LOCKED && r_state != LOCKED && r_lock_cnt != 16'hFFFF) begin
        r_lock_cnt <= r_lock_cnt + 16'd1;
      end
      // A wrap is a SEARCH slip step taken from offset 15.
      if (r_state == SEARCH && w_state_nxt == SEARCH && w_slip_nxt == 4'd0 &&
          r_slip == 4'd15 && r_slip_wraps != 16'hFFFF) begin
        r_slip_wraps <= r_slip_wraps + 16'd1;
      end
    end
  end

  assign lock_cnt   = r_lock_cnt;
  assign slip_wraps = r_slip_wraps;
`endif

endmodule

// File: tb/tb_lumi_deserializer.sv
`timescale 1ns/1ps
// tb_lumi_deserializer: serializer-model source driving the DDR line with random phase,
// checked against the alignment rules (lock time, slip behaviour, word content, resets).
module tb_lumi_deserializer;
  import lumi_pkg::*;

  localparam logic [15:0] SYNC       = 16'hBC50;
  localparam int          LOCK_COUNT = 8;
  localparam int          SLIP_WAIT  = 2;
  localparam int          LOCK_BOUND = 16 * (SLIP_WAIT + 1) + LOCK_COUNT + 8;
  localparam int          FILL       = 8;   // pipeline fill after reset release

  logic       clk_par   = 1'b0;
  logic       clk_ser   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       serInData = 1'b0;
  logic       realign   = 1'b0;
  logic       aligned;
  logic [3:0] slip;
  logic [1:0] state_dbg;
`ifdef LUMI_DESER_STATS_EN
  logic [15:0] lock_cnt;
  logic [15:0] slip_wraps;
`endif

  lumi_deserializer_if par_if ();

  lumi_deserializer #(
    .SYNC_WORD  (SYNC),
    .LOCK_COUNT (LOCK_COUNT),
    .SLIP_WAIT  (SLIP_WAIT)
  ) dut (
    .clk_par    (clk_par),
    .reset_n    (reset_n),
    .clk_ser    (clk_ser),
    .serInData  (serInData),
    .realign    (realign),
    .par_if     (par_if),
    .aligned    (aligned),
    .slip       (slip),
    .state_dbg  (state_dbg)
`ifdef LUMI_DESER_STATS_EN
    ,
    .lock_cnt   (lock_cnt),
    .slip_wraps (slip_wraps)
`endif
  );

  // clk_ser posedges at 2 mod 4; clk_par posedges fall on clk_ser negedges.
  initial forever #2 clk_ser = ~clk_ser;
  initial forever #16 clk_par = ~clk_par;

  int n_cmp = 0;
  int n_err = 0;

  // Source: 0 = SYNC stream, 1 = ramp from 1, 2 = all zeros. inj_req requests one 0xBC51.
  int         src_mode = 0;
  int         inj_req  = 0;
  logic [3:0] lock_slip;

  // Serializer model: MSB first, one bit per clk_ser edge, bits change midway between edges.
  initial begin : tx
    logic [15:0] w;
    logic [15:0] ramp_val;
    int          lead;
    int          prev_mode;
    int          inj_done;
    ramp_val  = 16'd1;
    prev_mode = 0;
    inj_done  = 0;
    lead      = $urandom_range(0, 15);
    #1;
    for (int i = 0; i < lead; i++) begin
      serInData = 1'($urandom);
      #2;
    end
    forever begin
      if (inj_req != inj_done) begin
        w = 16'hBC51;
        inj_done++;
      end else if (src_mode == 1) begin
        if (prev_mode != 1) ramp_val = 16'd1;
        w = ramp_val;
        ramp_val = ramp_val + 16'd1;
      end else if (src_mode == 2) begin
        w = 16'h0000;
      end else begin
        w = SYNC;
      end
      prev_mode = src_mode;
      for (int b = 15; b >= 0; b--) begin
        serInData = w[b];
        #2;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_lock(input int bound, output int cyc, output logic ok);
    ok  = 1'b0;
    cyc = 0;
    while (cyc < bound && !ok) begin
      @(negedge clk_par);
      cyc++;
      if (aligned === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int bound, output logic ok);
    int cyc;
    ok  = 1'b0;
    cyc = 0;
    while (cyc < bound && !ok) begin
      @(negedge clk_par);
      cyc++;
      if (state_dbg === st) ok = 1'b1;
    end
  endtask

  task automatic pulse_realign();
    @(negedge clk_par);
    realign = 1'b1;
    @(negedge clk_par);
    realign = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    src_mode = 0;
    repeat (4) @(negedge clk_par);
    n_cmp++; if (par_if.parOutWord !== 16'h0) begin n_err++; $display("FAIL reset_word: got %h want 0000", par_if.parOutWord); end
    n_cmp++; if (par_if.parOutValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", par_if.parOutValid); end
    n_cmp++; if (aligned !== 1'b0) begin n_err++; $display("FAIL reset_aligned: got %b want 0", aligned); end
    n_cmp++; if (slip !== 4'd0) begin n_err++; $display("FAIL reset_slip: got %0d want 0", slip); end
    n_cmp++; if (state_dbg !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", state_dbg); end
    reset_n = 1'b1;
  endtask

  task automatic test_sync_lock();
    int   cyc;
    logic ok;
    wait_lock(LOCK_BOUND + FILL, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL lock_time: no lock after %0d cycles, bound %0d", cyc, LOCK_BOUND + FILL); end
    n_cmp++; if (par_if.parOutWord !== SYNC) begin n_err++; $display("FAIL lock_word: got %h want %h", par_if.parOutWord, SYNC); end
    n_cmp++; if (par_if.parOutValid !== 1'b1) begin n_err++; $display("FAIL lock_valid: got %b want 1", par_if.parOutValid); end
    n_cmp++; if (state_dbg !== 2'b10) begin n_err++; $display("FAIL lock_state: got %b want 10", state_dbg); end
    lock_slip = slip;
  endtask

  task automatic test_ramp();
    logic        found;
    logic [15:0] prev;
    src_mode = 1;
    found    = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_par);
      if (par_if.parOutWord !== SYNC) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL ramp_start: ramp never appeared, word %h", par_if.parOutWord); end
    n_cmp++; if (par_if.parOutWord !== 16'h0001) begin n_err++; $display("FAIL ramp_first: got %h want 0001", par_if.parOutWord); end
    prev = par_if.parOutWord;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_par);
      n_cmp++; if (par_if.parOutWord !== prev + 16'd1) begin n_err++; $display("FAIL ramp_step: got %h want %h", par_if.parOutWord, prev + 16'd1); end
      n_cmp++; if (par_if.parOutValid !== 1'b1) begin n_err++; $display("FAIL ramp_valid: got %b want 1", par_if.parOutValid); end
      prev = prev + 16'd1;
    end
    src_mode = 0;
    found    = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_par);
      if (par_if.parOutWord === SYNC) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL ramp_back_sync: word %h want %h", par_if.parOutWord, SYNC); end
    n_cmp++; if (aligned !== 1'b1) begin n_err++; $display("FAIL ramp_aligned: got %b want 1", aligned); end
  endtask

  task automatic test_realign();
    int   cyc;
    logic ok;
    pulse_realign();
    n_cmp++; if (par_if.parOutValid !== 1'b0) begin n_err++; $display("FAIL realign_valid: got %b want 0", par_if.parOutValid); end
    n_cmp++; if (state_dbg !== 2'b00) begin n_err++; $display("FAIL realign_state: got %b want 00", state_dbg); end
    n_cmp++; if (slip !== lock_slip) begin n_err++; $display("FAIL realign_slip_kept: got %0d want %0d", slip, lock_slip); end
    wait_lock(LOCK_BOUND, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL realign_relock: no lock after %0d cycles", cyc); end
    n_cmp++; if (slip !== lock_slip) begin n_err++; $display("FAIL realign_relock_slip: got %0d want %0d", slip, lock_slip); end
    n_cmp++; if (par_if.parOutWord !== SYNC) begin n_err++; $display("FAIL realign_relock_word: got %h want %h", par_if.parOutWord, SYNC); end
  endtask

  // realign arriving on the edge of the LOCK_COUNT-th match must keep the FSM out of LOCKED.
  task automatic test_realign_race();
    int   cyc;
    logic ok;
    pulse_realign();
    wait_state(2'b01, 8, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL race_check_entry: state %b want 01", state_dbg); end
    // First match entered CHECK; LOCK_COUNT-2 more matches keep it there.
    repeat (LOCK_COUNT - 2) @(negedge clk_par);
    n_cmp++; if (state_dbg !== 2'b01) begin n_err++; $display("FAIL race_pre_state: got %b want 01", state_dbg); end
    realign = 1'b1;
    @(negedge clk_par);
    realign = 1'b0;
    n_cmp++; if (state_dbg !== 2'b00) begin n_err++; $display("FAIL race_state: got %b want 00", state_dbg); end
    n_cmp++; if (par_if.parOutValid !== 1'b0) begin n_err++; $display("FAIL race_valid: got %b want 0", par_if.parOutValid); end
    wait_lock(LOCK_BOUND, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL race_relock: no lock after %0d cycles", cyc); end
  endtask

  task automatic test_corrupt();
    int   cyc;
    logic ok;
    logic found;
    logic saw_lock;
    pulse_realign();
    wait_state(2'b01, 8, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL corrupt_check_entry: state %b want 01", state_dbg); end
    inj_req++;
    found    = 1'b0;
    saw_lock = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk_par);
      if (state_dbg === 2'b10) saw_lock = 1'b1;
      if (state_dbg === 2'b00) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL corrupt_to_search: state %b want 00", state_dbg); end
    n_cmp++; if (saw_lock !== 1'b0) begin n_err++; $display("FAIL corrupt_early_lock: locked %b want 0", saw_lock); end
    n_cmp++; if (slip !== 4'(lock_slip + 4'd1)) begin n_err++; $display("FAIL corrupt_slip_inc: got %0d want %0d", slip, 4'(lock_slip + 4'd1)); end
    wait_lock(LOCK_BOUND + FILL, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL corrupt_relock: no lock after %0d cycles", cyc); end
    n_cmp++; if (slip !== lock_slip) begin n_err++; $display("FAIL corrupt_relock_slip: got %0d want %0d", slip, lock_slip); end
    n_cmp++; if (cyc < 15 * (SLIP_WAIT + 1)) begin n_err++; $display("FAIL corrupt_full_cycle: relock after %0d cycles want >= %0d", cyc, 15 * (SLIP_WAIT + 1)); end
  endtask

  task automatic test_reset_midlock();
    int   cyc;
    logic ok;
    @(negedge clk_par);
    reset_n = 1'b0;
    @(negedge clk_par);
    n_cmp++; if (par_if.parOutWord !== 16'h0) begin n_err++; $display("FAIL midrst_word: got %h want 0000", par_if.parOutWord); end
    n_cmp++; if (par_if.parOutValid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", par_if.parOutValid); end
    n_cmp++; if (aligned !== 1'b0) begin n_err++; $display("FAIL midrst_aligned: got %b want 0", aligned); end
    n_cmp++; if (slip !== 4'd0) begin n_err++; $display("FAIL midrst_slip: got %0d want 0", slip); end
    n_cmp++; if (state_dbg !== 2'b00) begin n_err++; $display("FAIL midrst_state: got %b want 00", state_dbg); end
    repeat (2) @(negedge clk_par);
    reset_n = 1'b1;
    wait_lock(LOCK_BOUND + FILL, cyc, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL midrst_relock: no lock after %0d cycles", cyc); end
    n_cmp++; if (par_if.parOutWord !== SYNC) begin n_err++; $display("FAIL midrst_relock_word: got %h want %h", par_if.parOutWord, SYNC); end
    lock_slip = slip;
  endtask

`ifdef LUMI_DESER_STATS_EN
  task automatic test_stats_lock();
    int   cyc;
    logic ok;
    src_mode = 0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk_par);
    reset_n = 1'b1;
    wait_lock(LOCK_BOUND + FILL, cyc, ok);
    for (int i = 0; i < 2; i++) begin
      pulse_realign();
      wait_lock(LOCK_BOUND, cyc, ok);
    end
    n_cmp++; if (lock_cnt !== 16'd3) begin n_err++; $display("FAIL stats_lock_cnt: got %0d want 3", lock_cnt); end
  endtask

  task automatic test_stats_wraps();
    int         changes;
    int         cyc;
    logic [3:0] prev;
    src_mode = 2;
    repeat (4) @(negedge clk_par);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_par);
    reset_n = 1'b1;
    prev    = slip;
    changes = 0;
    cyc     = 0;
    while (changes < 40 && cyc < 40 * (SLIP_WAIT + 1) + FILL + 8) begin
      @(negedge clk_par);
      cyc++;
      if (slip !== prev) changes++;
      prev = slip;
    end
    n_cmp++; if (changes !== 40) begin n_err++; $display("FAIL stats_slip_steps: got %0d want 40", changes); end
    n_cmp++; if (slip_wraps !== 16'd2) begin n_err++; $display("FAIL stats_slip_wraps: got %0d want 2", slip_wraps); end
    n_cmp++; if (slip !== 4'd8) begin n_err++; $display("FAIL stats_slip_final: got %0d want 8", slip); end
    src_mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_sync_lock();
    test_ramp();
    test_realign();
    test_realign_race();
    test_corrupt();
    test_reset_midlock();
`ifdef LUMI_DESER_STATS_EN
    test_stats_lock();
    test_stats_wraps();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
